// File: rtl/i2c_burst_read.sv
// I2C master register burst read: S, addr+W, 1-2 register bytes, Sr, addr+R, 1-4 data bytes, P.
// Define I2C_BURST_READ_ACK_CHECK_EN to abort with nack when an address/register byte is not ACKed.
module i2c_burst_read #(
  parameter logic [15:0] CLK_DIV        = 16'd16,
  parameter logic [6:0]  SLAVE_ADDR     = 7'h36,
  parameter int unsigned REG_ADDR_BYTES = 1,
  parameter int unsigned READ_BYTES     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    scl,
  inout  logic                    sda,
  input  logic                    start,
  input  logic [15:0]             reg_addr,
  output logic                    ready,
  output logic                    done,
  output logic                    nack,
  output logic [8*READ_BYTES-1:0] regout
);
  localparam int unsigned RW      = 8 * READ_BYTES;
  localparam logic [15:0] DIV     = (CLK_DIV == 16'd0) ? 16'd1 : CLK_DIV;
  localparam logic [1:0]  LAST_RA = 2'(REG_ADDR_BYTES - 1);
  localparam logic [1:0]  LAST_RD = 2'(READ_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WADDR, S_RADDR, S_RSTART, S_RADR, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    q, q_n, byte_cnt, byte_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [15:0]   presc, presc_n, addr_q, addr_n;
  logic [RW-1:0] shift_q, shift_n, regout_n;
  logic          nack_n, scl_n, sda_o, sda_o_n, sda_e, sda_e_n;
  logic          sda_in, ack_fail, tick, slot_end;
  logic [7:0]    tx_byte;

  assign sda      = sda_e ? sda_o : 1'bz;
  assign sda_in   = sda;
  assign tick     = (presc == DIV - 16'd1);
  assign slot_end = tick && (q == 2'd3);
  assign ready    = (state == S_IDLE);
  assign done     = (state == S_DONE);

`ifdef I2C_BURST_READ_ACK_CHECK_EN
  assign ack_fail = sda_in;
`else
  assign ack_fail = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    q_n      = q;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    presc_n  = presc;
    addr_n   = addr_q;
    shift_n  = shift_q;
    regout_n = regout;
    nack_n   = nack;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_START;
          addr_n  = reg_addr;
          presc_n = '0;
          q_n     = '0;
          bit_n   = '0;
          byte_n  = '0;
          shift_n = '0;
          nack_n  = 1'b0;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        presc_n = tick ? '0 : presc + 16'd1;
        if (tick) q_n = q + 2'd1;
        if (slot_end) begin
          case (state)
            S_START: begin
              state_n = S_WADDR;
              bit_n   = '0;
            end
            S_WADDR, S_RADR, S_RADDR: begin
              if (bit_cnt == 4'd8) begin
                bit_n = '0;
                if (ack_fail) begin
                  state_n = S_STOP;
                  nack_n  = 1'b1;
                end else if (state == S_WADDR) begin
                  state_n = S_RADDR;
                  byte_n  = '0;
                end else if (state == S_RADR) begin
                  state_n = S_RDATA;
                  byte_n  = '0;
                end else if (byte_cnt == LAST_RA) begin
                  state_n = S_RSTART;
                end else begin
                  byte_n = byte_cnt + 2'd1;
                end
              end else begin
                bit_n = bit_cnt + 4'd1;
              end
            end
            S_RSTART: begin
              state_n = S_RADR;
              bit_n   = '0;
            end
            S_RDATA: begin
              if (bit_cnt == 4'd8) begin
                bit_n = '0;
                if (byte_cnt == LAST_RD) state_n = S_STOP;
                else                     byte_n = byte_cnt + 2'd1;
              end else begin
                bit_n   = bit_cnt + 4'd1;
                shift_n = {shift_q[RW-2:0], sda_in};
              end
            end
            S_STOP: begin
              state_n = S_DONE;
              if (!nack) regout_n = shift_q;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Pins are decoded from the next-state values so every change lands on the first clk of a quarter.
  always_comb begin
    scl_n   = 1'b1;
    sda_o_n = 1'b1;
    sda_e_n = 1'b0;
    tx_byte = {SLAVE_ADDR, 1'b0};
    if (state_n == S_RADR)
      tx_byte = {SLAVE_ADDR, 1'b1};
    else if (state_n == S_RADDR)
      tx_byte = (REG_ADDR_BYTES == 2 && byte_n == 2'd0) ? addr_n[15:8] : addr_n[7:0];
    case (state_n)
      S_START: begin
        sda_e_n = 1'b1;
        sda_o_n = ~q_n[1];
      end
      S_RSTART: begin
        sda_e_n = 1'b1;
        scl_n   = (q_n != 2'd0);
        sda_o_n = ~q_n[1];
      end
      S_STOP: begin
        sda_e_n = 1'b1;
        scl_n   = (q_n != 2'd0);
        sda_o_n = q_n[1];
      end
      S_WADDR, S_RADDR, S_RADR: begin
        scl_n = q_n[1];
        if (bit_n != 4'd8) begin
          sda_e_n = 1'b1;
          sda_o_n = tx_byte[3'd7 - bit_n[2:0]];
        end
      end
      S_RDATA: begin
        scl_n = q_n[1];
        if (bit_n == 4'd8) begin
          sda_e_n = 1'b1;
          sda_o_n = (byte_n == LAST_RD);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      q        <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      presc    <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
      regout   <= '0;
      nack     <= 1'b0;
      scl      <= 1'b1;
      sda_o    <= 1'b1;
      sda_e    <= 1'b0;
    end else begin
      state    <= state_n;
      q        <= q_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      presc    <= presc_n;
      addr_q   <= addr_n;
      shift_q  <= shift_n;
      regout   <= regout_n;
      nack     <= nack_n;
      scl      <= scl_n;
      sda_o    <= sda_o_n;
      sda_e    <= sda_e_n;
    end
  end
endmodule

// File: tb/tb_i2c_burst_read.sv
// Directed bench for i2c_burst_read: three instances share one I2C bus served by a behavioural slave.
module tb_i2c_burst_read;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] reg_addr = '0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic scl_a, scl_b, scl_c, ready_a, ready_b, ready_c;
  logic done_a, done_b, done_c, nack_a, nack_b, nack_c;
  logic [15:0] regout_a, regout_c;
  logic [31:0] regout_b;

  wire sda;
  pullup (sda);
  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;
  logic scl_bus;
  assign scl_bus = scl_a & scl_b & scl_c;

  int unsigned n_cmp = 0, n_err = 0;

  i2c_burst_read #(.CLK_DIV(16'd4)) u_a (
    .clk(clk), .rst(rst), .scl(scl_a), .sda(sda), .start(start_a), .reg_addr(reg_addr),
    .ready(ready_a), .done(done_a), .nack(nack_a), .regout(regout_a));
  i2c_burst_read #(.CLK_DIV(16'd1), .REG_ADDR_BYTES(2), .READ_BYTES(4)) u_b (
    .clk(clk), .rst(rst), .scl(scl_b), .sda(sda), .start(start_b), .reg_addr(reg_addr),
    .ready(ready_b), .done(done_b), .nack(nack_b), .regout(regout_b));
  i2c_burst_read #(.CLK_DIV(16'd0)) u_c (
    .clk(clk), .rst(rst), .scl(scl_c), .sda(sda), .start(start_c), .reg_addr(reg_addr),
    .ready(ready_c), .done(done_c), .nack(nack_c), .regout(regout_c));

  // Behavioural slave and bus decoder, sampled on the falling clk edge.
  logic        slave_present = 1'b1;
  logic [31:0] slave_data = '0;
  logic [7:0]  log_byte[$];
  logic        log_ack[$];
  int unsigned n_start = 0, n_stop = 0;
  logic pscl = 1'b1, psda = 1'b1, active = 1'b0, addr_phase = 1'b0;
  logic rd_mode = 1'b0, want_rd = 1'b0, mack = 1'b1;
  logic [7:0]  sh = '0;
  int unsigned sb = 0, sbyte = 0;

  function automatic logic slave_bit(input int unsigned k, input int unsigned i);
    logic [31:0] d;
    d = slave_data;
    return d[24 - 8*k + i];
  endfunction

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl_bus;
    cd = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (pscl && cs && psda && !cd) begin
      n_start++; active = 1'b1; addr_phase = 1'b1; rd_mode = 1'b0; sb = 0; slv_low = 1'b0;
    end else if (pscl && cs && !psda && cd) begin
      n_stop++; active = 1'b0; rd_mode = 1'b0; slv_low = 1'b0;
    end else if (active && cs && !pscl) begin
      if (sb < 8) sh = {sh[6:0], cd};
      else begin log_byte.push_back(sh); log_ack.push_back(cd); mack = cd; end
      sb++;
    end else if (active && !cs && pscl) begin
      if (sb == 8) begin
        if (rd_mode) slv_low = 1'b0;
        else begin
          if (addr_phase) want_rd = sh[0];
          slv_low = slave_present && (!addr_phase || sh[7:1] == 7'h36);
        end
      end else if (sb == 9) begin
        sb = 0;
        if (addr_phase) begin
          addr_phase = 1'b0; rd_mode = want_rd && !mack; sbyte = 0;
        end else if (rd_mode) begin
          if (mack) rd_mode = 1'b0; else sbyte++;
        end
        slv_low = rd_mode && !slave_bit(sbyte, 7);
      end else if (sb != 0) begin
        slv_low = rd_mode && !slave_bit(sbyte, 7 - sb);
      end
    end
    pscl = cs; psda = cd;
  end

  task automatic clear_log();
    log_byte.delete(); log_ack.delete(); n_start = 0; n_stop = 0;
  endtask

  task automatic run_txn(input int unsigned sel, input logic [15:0] ra, input int unsigned budget,
                         output int unsigned edges, output logic timeout);
    @(negedge clk);
    reg_addr = ra;
    case (sel) 0: start_a = 1'b1; 1: start_b = 1'b1; default: start_c = 1'b1; endcase
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    edges = 0; timeout = 1'b1;
    while (edges < budget) begin
      @(negedge clk);
      if ((sel == 0 && done_a) || (sel == 1 && done_b) || (sel == 2 && done_c)) begin
        timeout = 1'b0; break;
      end
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (scl_a !== 1'b1) begin n_err++; $display("FAIL reset_scl_a: got %b want 1", scl_a); end
    n_cmp++; if (scl_b !== 1'b1) begin n_err++; $display("FAIL reset_scl_b: got %b want 1", scl_b); end
    n_cmp++; if (scl_c !== 1'b1) begin n_err++; $display("FAIL reset_scl_c: got %b want 1", scl_c); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda); end
    n_cmp++; if ({ready_a, ready_b, ready_c} !== 3'b111) begin n_err++; $display("FAIL reset_ready: got %b want 111", {ready_a, ready_b, ready_c}); end
    n_cmp++; if ({done_a, done_b, done_c} !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b want 000", {done_a, done_b, done_c}); end
    n_cmp++; if ({nack_a, nack_b, nack_c} !== 3'b000) begin n_err++; $display("FAIL reset_nack: got %b want 000", {nack_a, nack_b, nack_c}); end
    n_cmp++; if ({regout_a, regout_b, regout_c} !== 64'd0) begin n_err++; $display("FAIL reset_regout: got %h want 0", {regout_a, regout_b, regout_c}); end
    rst = 1'b0;
  endtask

  task automatic test_default_read();
    int unsigned e;
    logic to;
    logic [7:0] exp_b [5] = '{8'h6C, 8'h0E, 8'h6D, 8'h0A, 8'hBC};
    logic       exp_k [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    slave_present = 1'b1; slave_data = 32'h0ABC_0000; clear_log();
    run_txn(0, 16'h000E, 1000, e, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL default_timeout: no done within 1000 edges"); end
    n_cmp++; if (e !== 768) begin n_err++; $display("FAIL default_done_edge: got %0d want 768", e); end
    n_cmp++; if (regout_a !== 16'h0ABC) begin n_err++; $display("FAIL default_regout: got %h want 0abc", regout_a); end
    n_cmp++; if (nack_a !== 1'b0) begin n_err++; $display("FAIL default_nack: got %b want 0", nack_a); end
    n_cmp++; if (n_start !== 2 || n_stop !== 1) begin n_err++; $display("FAIL default_start_stop: got %0d/%0d want 2/1", n_start, n_stop); end
    n_cmp++; if (log_byte.size() !== 5) begin n_err++; $display("FAIL default_nbytes: got %0d want 5", log_byte.size()); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (log_byte[i] !== exp_b[i] || log_ack[i] !== exp_k[i]) begin
        n_err++; $display("FAIL default_byte%0d: got %h/%b want %h/%b", i, log_byte[i], log_ack[i], exp_b[i], exp_k[i]);
      end
    end
    @(negedge clk);
    n_cmp++; if (ready_a !== 1'b1 || done_a !== 1'b0) begin n_err++; $display("FAIL default_after_done: ready/done got %b%b want 10", ready_a, done_a); end
  endtask

  task automatic test_wide_read();
    int unsigned e;
    logic to;
    logic [7:0] exp_b [8] = '{8'h6C, 8'h12, 8'h34, 8'h6D, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    slave_present = 1'b1; slave_data = 32'hDEAD_BEEF; clear_log();
    run_txn(1, 16'h1234, 600, e, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL wide_timeout: no done within 600 edges"); end
    n_cmp++; if (e !== 300) begin n_err++; $display("FAIL wide_done_edge: got %0d want 300", e); end
    n_cmp++; if (regout_b !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wide_regout: got %h want deadbeef", regout_b); end
    n_cmp++; if (log_byte.size() !== 8) begin n_err++; $display("FAIL wide_nbytes: got %0d want 8", log_byte.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (log_byte[i] !== exp_b[i] || log_ack[i] !== (i == 7)) begin
        n_err++; $display("FAIL wide_byte%0d: got %h/%b want %h/%b", i, log_byte[i], log_ack[i], exp_b[i], (i == 7));
      end
    end
  endtask

  task automatic test_ack_check();
    int unsigned e;
    logic to;
    slave_present = 1'b0; clear_log();
    run_txn(0, 16'h000E, 1000, e, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL nack_timeout: no done within 1000 edges"); end
    n_cmp++; if (n_stop !== 1) begin n_err++; $display("FAIL nack_stop: got %0d want 1", n_stop); end
`ifdef I2C_BURST_READ_ACK_CHECK_EN
    n_cmp++; if (e !== 176) begin n_err++; $display("FAIL nack_done_edge: got %0d want 176", e); end
    n_cmp++; if (nack_a !== 1'b1) begin n_err++; $display("FAIL nack_flag: got %b want 1", nack_a); end
    n_cmp++; if (regout_a !== 16'h0ABC) begin n_err++; $display("FAIL nack_regout: got %h want 0abc", regout_a); end
    n_cmp++; if (log_byte.size() !== 1 || log_byte[0] !== 8'h6C || log_ack[0] !== 1'b1) begin
      n_err++; $display("FAIL nack_bus: got %0d bytes first %h/%b want 1 byte 6c/1", log_byte.size(), log_byte[0], log_ack[0]);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (nack_a !== 1'b1) begin n_err++; $display("FAIL nack_hold: got %b want 1", nack_a); end
`else
    n_cmp++; if (e !== 768) begin n_err++; $display("FAIL noack_done_edge: got %0d want 768", e); end
    n_cmp++; if (nack_a !== 1'b0) begin n_err++; $display("FAIL noack_flag: got %b want 0", nack_a); end
    n_cmp++; if (regout_a !== 16'hFFFF) begin n_err++; $display("FAIL noack_regout: got %h want ffff", regout_a); end
    n_cmp++; if (log_byte.size() !== 5) begin n_err++; $display("FAIL noack_nbytes: got %0d want 5", log_byte.size()); end
`endif
    slave_present = 1'b1;
  endtask

  task automatic test_start_ignored();
    int unsigned nd = 0, first = 0;
    logic busy202 = 1'b1;
    slave_data = 32'h0ABC_0000;
    @(negedge clk);
    reg_addr = 16'h000E; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int unsigned e = 0; e < 1100; e++) begin
      @(negedge clk);
      if (done_a) begin nd++; if (nd == 1) first = e; end
      if (e == 200) start_a = 1'b1;
      if (e == 201) start_a = 1'b0;
      if (e == 202) busy202 = ready_a;
      @(posedge clk);
    end
    @(negedge clk);
    n_cmp++; if (nd !== 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    n_cmp++; if (first !== 768) begin n_err++; $display("FAIL ignore_done_edge: got %0d want 768", first); end
    n_cmp++; if (busy202 !== 1'b0) begin n_err++; $display("FAIL ignore_ready_busy: got %b want 0", busy202); end
    n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL ignore_ready_end: got %b want 1", ready_a); end
    n_cmp++; if (regout_a !== 16'h0ABC || nack_a !== 1'b0) begin n_err++; $display("FAIL ignore_result: got %h/%b want 0abc/0", regout_a, nack_a); end
  endtask

  task automatic test_back_to_back();
    int unsigned nd = 0, d1 = 0, d2 = 0;
    logic r769 = 1'b0, r770 = 1'b1;
    @(negedge clk);
    reg_addr = 16'h000E; start_a = 1'b1;
    @(posedge clk);
    for (int unsigned e = 0; e < 1700; e++) begin
      @(negedge clk);
      if (done_a) begin nd++; if (nd == 1) d1 = e; else d2 = e; end
      if (e == 769) r769 = ready_a;
      if (e == 770) begin r770 = ready_a; start_a = 1'b0; end
      @(posedge clk);
    end
    n_cmp++; if (d1 !== 768) begin n_err++; $display("FAIL b2b_first_done: got %0d want 768", d1); end
    n_cmp++; if (r769 !== 1'b1) begin n_err++; $display("FAIL b2b_ready_rise: got %b want 1", r769); end
    n_cmp++; if (r770 !== 1'b0) begin n_err++; $display("FAIL b2b_retrigger: got %b want 0", r770); end
    n_cmp++; if (nd !== 2 || d2 !== 1538) begin n_err++; $display("FAIL b2b_second_done: got %0d dones at %0d want 2 at 1538", nd, d2); end
  endtask

  task automatic test_reset_mid();
    int unsigned e;
    logic to;
    @(negedge clk);
    reg_addr = 16'h000E; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (scl_a !== 1'b1) begin n_err++; $display("FAIL midrst_scl: got %b want 1", scl_a); end
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL midrst_sda: got %b want 1", sda); end
    n_cmp++; if (ready_a !== 1'b1 || done_a !== 1'b0) begin n_err++; $display("FAIL midrst_ready_done: got %b%b want 10", ready_a, done_a); end
    n_cmp++; if (regout_a !== 16'h0000) begin n_err++; $display("FAIL midrst_regout: got %h want 0000", regout_a); end
    rst = 1'b0;
    run_txn(0, 16'h000E, 1000, e, to);
    n_cmp++; if (to !== 1'b0 || e !== 768) begin n_err++; $display("FAIL midrst_rerun_edge: got %0d (timeout %b) want 768", e, to); end
    n_cmp++; if (regout_a !== 16'h0ABC) begin n_err++; $display("FAIL midrst_rerun_regout: got %h want 0abc", regout_a); end
  endtask

  task automatic test_clkdiv_zero();
    int unsigned e;
    logic to;
    slave_data = 32'h0ABC_0000; clear_log();
    run_txn(2, 16'h000E, 500, e, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL div0_timeout: no done within 500 edges"); end
    n_cmp++; if (e !== 192) begin n_err++; $display("FAIL div0_done_edge: got %0d want 192", e); end
    n_cmp++; if (regout_c !== 16'h0ABC || nack_c !== 1'b0) begin n_err++; $display("FAIL div0_result: got %h/%b want 0abc/0", regout_c, nack_c); end
    n_cmp++; if (log_byte.size() !== 5 || log_byte[1] !== 8'h0E) begin n_err++; $display("FAIL div0_bus: got %0d bytes reg %h want 5 bytes reg 0e", log_byte.size(), log_byte[1]); end
  endtask

  initial begin
    test_reset();
    test_default_read();
    test_wide_read();
    test_ack_check();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_clkdiv_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
